pipeline_hazard_unit: RTL and testbench

Parametrised hazard controller for the RISC-V pipeline. It replaces the fixed two-stage forwarding-only logic and adds a load-use stall, branch-redirect flush and performance counters. It keeps its own shadow pipeline of the destination-register and control bits for every stage from ID/EX to writeback. From that state it drives the forwarding-mux selects for the EX operands and the stall/flush controls for the IF/ID, ID/EX and EX/MEM buffers.

---
 rtl/pipeline_hazard_unit.sv | 149 ++++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_unit.sv
// rtl/pipeline_hazard_unit.sv - forwarding select, load-use stall and redirect flush controller
//
// Tracks a shadow copy of the destination/control bits of every stage from
// ID/EX (entry 0) down to the last forwarding stage (entry FWD_STAGES), and
// derives the EX operand forwarding selects plus the stall/flush controls.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   id_valid                   IF/ID holds a real instruction
//   id_rs1, id_rs2             decoded source registers
//   id_use_rs1, id_use_rs2     source is actually read
//   id_rd                      decoded destination register
//   id_regwrite, id_memread    decoded control bits
//   br_taken                   taken branch resolved at stage BR_RESOLVE
//   fwd_a, fwd_b               EX operand select (0 = regfile, k = stage k)
//   stall                      hold PC and IF/ID, bubble into ID/EX
//   flush_if_id/id_ex/ex_mem   clear the named pipeline buffer
//   stall_cnt, flush_cnt       saturating event counters

module pipeline_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_STAGE = 2,
  parameter int BR_RESOLVE = 1,
  parameter int CNT_W      = 32,
  localparam int FW        = $clog2(FWD_STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              br_taken,
  output logic [FW-1:0]     fwd_a,
  output logic [FW-1:0]     fwd_b,
  output logic              stall,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Shadow pipeline: entry 0 is the instruction in EX.
  logic              s_valid    [0:FWD_STAGES];
  logic [REG_AW-1:0] s_rd       [0:FWD_STAGES];
  logic              s_regwrite [0:FWD_STAGES];
  logic              s_memread  [0:FWD_STAGES];

  // Source fields are only needed for the EX instruction.
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic              ex_use_rs1;
  logic              ex_use_rs2;

  logic redirect;
  logic load_hit;

  assign redirect     = br_taken;
  assign flush_if_id  = redirect;
  assign flush_id_ex  = redirect;
  assign flush_ex_mem = (BR_RESOLVE == 1) ? redirect : 1'b0;

  // Load-use: an ID source depends on a load that will not yet have its
  // data at a forwarding stage when the consumer reaches EX.
  always_comb begin
    load_hit = 1'b0;
    for (int j = 0; j < LOAD_STAGE - 1; j++) begin
      if (s_valid[j] && s_regwrite[j] && s_memread[j] && (s_rd[j] != '0) &&
          ((id_use_rs1 && (s_rd[j] == id_rs1)) ||
           (id_use_rs2 && (s_rd[j] == id_rs2)))) begin
        load_hit = 1'b1;
      end
    end
  end

  // A redirect squashes the consumer anyway, so it wins over the stall.
  assign stall = id_valid & ~redirect & load_hit;

  // Nearest producer wins; a too-young load yields the register file value.
  always_comb begin : fwd_select
    logic done_a;
    logic done_b;
    fwd_a  = '0;
    fwd_b  = '0;
    done_a = 1'b0;
    done_b = 1'b0;
    for (int k = 1; k <= FWD_STAGES; k++) begin
      if (!done_a && ex_use_rs1 && (ex_rs1 != '0) && s_valid[k] &&
          s_regwrite[k] && (s_rd[k] == ex_rs1)) begin
        done_a = 1'b1;
        if (!(s_memread[k] && (k < LOAD_STAGE))) fwd_a = FW'(k);
      end
      if (!done_b && ex_use_rs2 && (ex_rs2 != '0) && s_valid[k] &&
          s_regwrite[k] && (s_rd[k] == ex_rs2)) begin
        done_b = 1'b1;
        if (!(s_memread[k] && (k < LOAD_STAGE))) fwd_b = FW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= FWD_STAGES; k++) begin
        s_valid[k]    <= 1'b0;
        s_rd[k]       <= '0;
        s_regwrite[k] <= 1'b0;
        s_memread[k]  <= 1'b0;
      end
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_use_rs1 <= 1'b0;
      ex_use_rs2 <= 1'b0;
    end else begin
      s_valid[0]    <= id_valid & ~stall & ~flush_id_ex;
      s_rd[0]       <= id_rd;
      s_regwrite[0] <= id_regwrite;
      s_memread[0]  <= id_memread;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_use_rs1    <= id_use_rs1;
      ex_use_rs2    <= id_use_rs2;
      for (int k = 1; k <= FWD_STAGES; k++) begin
        s_valid[k]    <= s_valid[k-1];
        s_rd[k]       <= s_rd[k-1];
        s_regwrite[k] <= s_regwrite[k-1];
        s_memread[k]  <= s_memread[k-1];
      end
      // The branch sitting in EX/MEM squashes what is moving into it.
      if (flush_ex_mem) s_valid[1] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb/tb_pipeline_hazard_unit.sv - randomized and directed checks of pipeline_hazard_unit
module tb_pipeline_hazard_unit;

  logic clk = 1'b0;
  logic reset;
  logic id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic id_use_rs1, id_use_rs2, id_regwrite, id_memread, br_taken;

  logic [1:0] a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b;
  logic a_stall, a_flush_if_id, a_flush_id_ex, a_flush_ex_mem;
  logic b_stall, b_flush_if_id, b_flush_id_ex, b_flush_ex_mem;
  logic [3:0] a_stall_cnt, a_flush_cnt;
  logic [7:0] b_stall_cnt, b_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_unit #(.REG_AW(5), .FWD_STAGES(2), .LOAD_STAGE(2), .BR_RESOLVE(1), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .br_taken(br_taken),
    .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .stall(a_stall), .flush_if_id(a_flush_if_id),
    .flush_id_ex(a_flush_id_ex), .flush_ex_mem(a_flush_ex_mem),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt));

  pipeline_hazard_unit #(.REG_AW(5), .FWD_STAGES(3), .LOAD_STAGE(3), .BR_RESOLVE(0), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .br_taken(br_taken),
    .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .stall(b_stall), .flush_if_id(b_flush_if_id),
    .flush_id_ex(b_flush_id_ex), .flush_ex_mem(b_flush_ex_mem),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt));

  // Reference model: a history of instructions that entered EX, newest first.
  typedef struct {
    bit v; int rs1; int rs2; bit u1; bit u2; int rd; bit rw; bit mr;
  } ins_t;

  ins_t hist_a[$];
  ins_t hist_b[$];
  int   m_scnt[2];
  int   m_fcnt[2];

  function automatic int cfg_fs(int c);   return (c == 0) ? 2 : 3;    endfunction
  function automatic int cfg_ls(int c);   return (c == 0) ? 2 : 3;    endfunction
  function automatic int cfg_br(int c);   return (c == 0) ? 1 : 0;    endfunction
  function automatic int cfg_max(int c);  return (c == 0) ? 15 : 255; endfunction

  function automatic ins_t ent(int c, int k);
    if (c == 0) return hist_a[k];
    return hist_b[k];
  endfunction

  function automatic bit writes(int c, int k, int r);
    ins_t e;
    e = ent(c, k);
    return e.v && e.rw && (e.rd == r) && (r != 0);
  endfunction

  function automatic int exp_fwd(int c, bit opb);
    ins_t x;
    ins_t p;
    int r;
    bit u;
    x = ent(c, 0);
    r = opb ? x.rs2 : x.rs1;
    u = opb ? x.u2 : x.u1;
    if (!u) return 0;
    for (int k = 1; k <= cfg_fs(c); k++) begin
      if (writes(c, k, r)) begin
        p = ent(c, k);
        return (p.mr && (k < cfg_ls(c))) ? 0 : k;
      end
    end
    return 0;
  endfunction

  function automatic bit exp_stall(int c);
    ins_t e;
    if (!id_valid || br_taken) return 0;
    for (int j = 0; j <= cfg_ls(c) - 2; j++) begin
      e = ent(c, j);
      if (e.mr && ((id_use_rs1 && writes(c, j, int'(id_rs1))) ||
                   (id_use_rs2 && writes(c, j, int'(id_rs2))))) return 1;
    end
    return 0;
  endfunction

  task automatic model_reset();
    ins_t z;
    z = '{default: 0};
    hist_a.delete();
    hist_b.delete();
    for (int i = 0; i <= 2; i++) hist_a.push_back(z);
    for (int i = 0; i <= 3; i++) hist_b.push_back(z);
    m_scnt[0] = 0; m_scnt[1] = 0;
    m_fcnt[0] = 0; m_fcnt[1] = 0;
  endtask

  task automatic model_update();
    bit st[2];
    ins_t n;
    ins_t old;
    if (reset) begin
      model_reset();
      return;
    end
    st[0] = exp_stall(0);
    st[1] = exp_stall(1);
    n.rs1 = int'(id_rs1); n.rs2 = int'(id_rs2);
    n.u1 = id_use_rs1; n.u2 = id_use_rs2;
    n.rd = int'(id_rd); n.rw = id_regwrite; n.mr = id_memread;
    for (int c = 0; c < 2; c++) begin
      if (st[c] && (m_scnt[c] < cfg_max(c))) m_scnt[c]++;
      if (br_taken && (m_fcnt[c] < cfg_max(c))) m_fcnt[c]++;
      n.v = id_valid && !st[c] && !br_taken;
      old = ent(c, 0);
      if (br_taken && (cfg_br(c) == 1)) old.v = 0;
      if (c == 0) begin
        hist_a[0] = old;
        hist_a.push_front(n);
        void'(hist_a.pop_back());
      end else begin
        hist_b[0] = old;
        hist_b.push_front(n);
        void'(hist_b.pop_back());
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit rw, bit mr);
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_use_rs1 = u1; id_use_rs2 = u2; id_rd = 5'(rd);
    id_regwrite = rw; id_memread = mr;
  endtask

  task automatic alu(int rd, int rs1, int rs2); instr(1, rs1, rs2, 1, 1, rd, 1, 0); endtask
  task automatic load(int rd, int rs1);         instr(1, rs1, 0, 1, 0, rd, 1, 1);  endtask
  task automatic bubble();                      instr(0, 0, 0, 0, 0, 0, 0, 0);     endtask

  task automatic drain(int n);
    bubble();
    br_taken = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bubble();
    br_taken = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    alu(1, 2, 3);
    @(negedge clk);
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0d want 0", a_stall); end
    checks++; if (a_fwd_a !== 2'd0 || a_fwd_b !== 2'd0) begin errors++; $display("FAIL reset_fwd: got %0d/%0d want 0/0", a_fwd_a, a_fwd_b); end
    checks++; if ({a_flush_if_id, a_flush_id_ex, a_flush_ex_mem} !== 3'b000) begin errors++; $display("FAIL reset_flush: got %b want 000", {a_flush_if_id, a_flush_id_ex, a_flush_ex_mem}); end
    checks++; if (a_stall_cnt !== 4'd0 || a_flush_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt_a: got %0d/%0d want 0/0", a_stall_cnt, a_flush_cnt); end
    checks++; if (b_stall_cnt !== 8'd0 || b_stall !== 1'b0) begin errors++; $display("FAIL reset_b: got cnt %0d stall %0d want 0/0", b_stall_cnt, b_stall); end
    step();
  endtask

  task automatic test_forward();
    drain(4);
    alu(5, 1, 2); step();
    alu(6, 5, 7); step();
    bubble();
    @(negedge clk);
    checks++; if (a_fwd_a !== 2'd1) begin errors++; $display("FAIL fwd_ex_mem_a: got %0d want 1", a_fwd_a); end
    checks++; if (a_fwd_b !== 2'd0) begin errors++; $display("FAIL fwd_ex_mem_b: got %0d want 0", a_fwd_b); end
    checks++; if (b_fwd_a !== 2'd1) begin errors++; $display("FAIL fwd_ex_mem_cfgb: got %0d want 1", b_fwd_a); end
    step();
    alu(5, 1, 2); step();
    alu(10, 11, 12); step();
    alu(6, 5, 7); step();
    bubble();
    @(negedge clk);
    checks++; if (a_fwd_a !== 2'd2) begin errors++; $display("FAIL fwd_mem_wb_a: got %0d want 2", a_fwd_a); end
    checks++; if (b_fwd_a !== 2'd2) begin errors++; $display("FAIL fwd_mem_wb_cfgb: got %0d want 2", b_fwd_a); end
    step();
  endtask

  task automatic test_back_to_back();
    drain(4);
    alu(5, 1, 2); step();
    instr(1, 0, 0, 1, 0, 5, 1, 0); step();
    alu(6, 5, 5); step();
    bubble();
    @(negedge clk);
    checks++; if (a_fwd_a !== 2'd1 || a_fwd_b !== 2'd1) begin errors++; $display("FAIL b2b_nearest: got %0d/%0d want 1/1", a_fwd_a, a_fwd_b); end
    checks++; if (b_fwd_a !== 2'd1) begin errors++; $display("FAIL b2b_nearest_cfgb: got %0d want 1", b_fwd_a); end
    step();
  endtask

  task automatic test_load_use();
    drain(4);
    load(8, 2); step();
    alu(9, 8, 8);
    @(negedge clk);
    checks++; if (a_stall !== 1'b1 || b_stall !== 1'b1) begin errors++; $display("FAIL lu_stall_c1: got %0d/%0d want 1/1", a_stall, b_stall); end
    step();
    @(negedge clk);
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL lu_single_stall: got %0d want 0", a_stall); end
    checks++; if (b_stall !== 1'b1) begin errors++; $display("FAIL lu_second_stall_cfgb: got %0d want 1", b_stall); end
    step();
    @(negedge clk);
    checks++; if (a_fwd_a !== 2'd2 || a_fwd_b !== 2'd2) begin errors++; $display("FAIL lu_fwd: got %0d/%0d want 2/2", a_fwd_a, a_fwd_b); end
    checks++; if (a_stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d want 1", a_stall_cnt); end
    checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL lu_release_cfgb: got %0d want 0", b_stall); end
    step();
    bubble();
    @(negedge clk);
    checks++; if (b_fwd_a !== 2'd3 || b_stall_cnt !== 8'd2) begin errors++; $display("FAIL lu_cfgb: got fwd %0d cnt %0d want 3/2", b_fwd_a, b_stall_cnt); end
    step();
    drain(4);
    load(0, 2); step();
    alu(9, 0, 0);
    @(negedge clk);
    checks++; if (a_stall !== 1'b0 || b_stall !== 1'b0) begin errors++; $display("FAIL lu_x0: got %0d/%0d want 0/0", a_stall, b_stall); end
    step();
  endtask

  task automatic test_redirect();
    drain(4);
    load(8, 2); step();
    alu(9, 8, 8);
    br_taken = 1'b1;
    @(negedge clk);
    checks++; if (a_stall !== 1'b0 || b_stall !== 1'b0) begin errors++; $display("FAIL br_over_stall: got %0d/%0d want 0/0", a_stall, b_stall); end
    checks++; if ({a_flush_if_id, a_flush_id_ex, a_flush_ex_mem} !== 3'b111) begin errors++; $display("FAIL br_flush_a: got %b want 111", {a_flush_if_id, a_flush_id_ex, a_flush_ex_mem}); end
    checks++; if ({b_flush_if_id, b_flush_id_ex, b_flush_ex_mem} !== 3'b110) begin errors++; $display("FAIL br_flush_cfgb: got %b want 110", {b_flush_if_id, b_flush_id_ex, b_flush_ex_mem}); end
    step();
    br_taken = 1'b0;
    alu(10, 9, 8);
    @(negedge clk);
    checks++; if (a_flush_cnt !== 4'd1 || b_flush_cnt !== 8'd1) begin errors++; $display("FAIL br_flush_cnt: got %0d/%0d want 1/1", a_flush_cnt, b_flush_cnt); end
    checks++; if (a_flush_if_id !== 1'b0 || a_stall !== 1'b0) begin errors++; $display("FAIL br_after: got flush %0d stall %0d want 0/0", a_flush_if_id, a_stall); end
    step();
    bubble();
    @(negedge clk);
    checks++; if (a_fwd_a !== 2'd0 || a_fwd_b !== 2'd0) begin errors++; $display("FAIL br_squashed: got %0d/%0d want 0/0", a_fwd_a, a_fwd_b); end
    step();
  endtask

  task automatic test_saturate();
    drain(4);
    load(8, 8);
    repeat (40) step();
    @(negedge clk);
    checks++; if (a_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_stall_cnt: got %0d want 15", a_stall_cnt); end
    checks++; if (int'(b_stall_cnt) !== m_scnt[1]) begin errors++; $display("FAIL sat_cfgb_cnt: got %0d want %0d", b_stall_cnt, m_scnt[1]); end
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (a_stall_cnt !== 4'd0 || b_stall_cnt !== 8'd0) begin errors++; $display("FAIL mid_reset_cnt: got %0d/%0d want 0/0", a_stall_cnt, b_stall_cnt); end
    checks++; if (a_stall !== 1'b0 || b_stall !== 1'b0) begin errors++; $display("FAIL mid_reset_shadow: got %0d/%0d want 0/0", a_stall, b_stall); end
    checks++; if (a_flush_cnt !== 4'd0 || a_fwd_a !== 2'd0) begin errors++; $display("FAIL mid_reset_misc: got %0d/%0d want 0/0", a_flush_cnt, a_fwd_a); end
    step();
  endtask

  task automatic test_random();
    int g_fa, g_fb, g_cs, g_cf;
    bit g_st;
    bit [2:0] g_fl, w_fl;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 79) == 0);
      instr($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1));
      br_taken = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        g_fa = (c == 0) ? int'(a_fwd_a) : int'(b_fwd_a);
        g_fb = (c == 0) ? int'(a_fwd_b) : int'(b_fwd_b);
        g_st = (c == 0) ? a_stall : b_stall;
        g_fl = (c == 0) ? {a_flush_if_id, a_flush_id_ex, a_flush_ex_mem}
                        : {b_flush_if_id, b_flush_id_ex, b_flush_ex_mem};
        g_cs = (c == 0) ? int'(a_stall_cnt) : int'(b_stall_cnt);
        g_cf = (c == 0) ? int'(a_flush_cnt) : int'(b_flush_cnt);
        w_fl = {br_taken, br_taken, br_taken && (cfg_br(c) == 1)};
        checks++; if (g_fa !== exp_fwd(c, 0)) begin errors++; $display("FAIL rnd_fwd_a cfg%0d cyc%0d: got %0d want %0d", c, n, g_fa, exp_fwd(c, 0)); end
        checks++; if (g_fb !== exp_fwd(c, 1)) begin errors++; $display("FAIL rnd_fwd_b cfg%0d cyc%0d: got %0d want %0d", c, n, g_fb, exp_fwd(c, 1)); end
        checks++; if (g_st !== exp_stall(c)) begin errors++; $display("FAIL rnd_stall cfg%0d cyc%0d: got %0d want %0d", c, n, g_st, exp_stall(c)); end
        checks++; if (g_fl !== w_fl) begin errors++; $display("FAIL rnd_flush cfg%0d cyc%0d: got %b want %b", c, n, g_fl, w_fl); end
        checks++; if (g_cs !== m_scnt[c]) begin errors++; $display("FAIL rnd_stall_cnt cfg%0d cyc%0d: got %0d want %0d", c, n, g_cs, m_scnt[c]); end
        checks++; if (g_cf !== m_fcnt[c]) begin errors++; $display("FAIL rnd_flush_cnt cfg%0d cyc%0d: got %0d want %0d", c, n, g_cf, m_fcnt[c]); end
      end
      step();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    br_taken = 1'b0;
    bubble();
    model_reset();
    #1;
    test_reset();
    test_forward();
    test_back_to_back();
    test_load_use();
    test_redirect();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
